// File: rtl/checker_pkg.sv
// Shared definitions for the implication checker.
//   CNT_W_DEFAULT     - default width of counters and the cycle timestamp
//   checker_status_t  - packed status bundle for debug readout
//   sat_inc           - saturating increment used by the pass/fail counters
package checker_pkg;

  localparam int CNT_W_DEFAULT = 16;

  typedef struct packed {
    logic                     failSticky;
    logic [CNT_W_DEFAULT-1:0] failCount;
    logic [CNT_W_DEFAULT-1:0] passCount;
    logic [CNT_W_DEFAULT-1:0] firstFailTime;
  } checker_status_t;

  // Operates on a 32-bit container so one function serves every counter
  // width up to 32; the caller supplies its own ceiling.
  function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                          input logic [31:0] maxValue);
    return (value >= maxValue) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/obligation_pipe.sv
// DELAY-deep shift register of outstanding obligations.
// Ports:
//   i_clk        - clock, all state on rising edge
//   i_flush      - synchronous flush, discards every in-flight obligation
//   i_obligation - new obligation entering stage 0
//   o_matured    - obligation reaching its evaluation edge this cycle
//   o_anyPending - OR of all stages
module obligation_pipe #(
  parameter int DELAY = 1
) (
  input  logic i_clk,
  input  logic i_flush,
  input  logic i_obligation,
  output logic o_matured,
  output logic o_anyPending
);

  logic [DELAY-1:0] r_pend;

  // A single-stage pipe has no lower slice to shift from, so it gets its own
  // register process instead of a concatenation with an empty range.
  if (DELAY == 1) begin : g_single
    always_ff @(posedge i_clk) begin
      if (i_flush) r_pend <= '0;
      else         r_pend <= i_obligation;
    end
  end else begin : g_shift
    always_ff @(posedge i_clk) begin
      if (i_flush) r_pend <= '0;
      else         r_pend <= {r_pend[DELAY-2:0], i_obligation};
    end
  end

  assign o_matured    = r_pend[DELAY-1];
  assign o_anyPending = |r_pend;

endmodule

// File: rtl/implication_checker.sv
// Run-time checker for "antecedent |-> ##DELAY consequent".
// Ports:
//   CLK, RESET      - clock and synchronous active-high reset
//   enable          - gates creation of new obligations
//   antecedent      - trigger
//   consequent      - must be high DELAY cycles after an enabled trigger
//   clear           - synchronous clear, identical in effect to RESET
//   fail_pulse      - one-cycle pulse per failed obligation
//   fail_sticky     - set on first failure, held until RESET/clear
//   pass_count      - saturating count of satisfied obligations
//   fail_count      - saturating count of failed obligations
//   first_fail_time - cycle counter value captured at the first failure
//   pending         - any obligation outstanding
module implication_checker
  import checker_pkg::*;
#(
  parameter int DELAY = 1,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             enable,
  input  logic             antecedent,
  input  logic             consequent,
  input  logic             clear,
  output logic             fail_pulse,
  output logic             fail_sticky,
  output logic [CNT_W-1:0] pass_count,
  output logic [CNT_W-1:0] fail_count,
  output logic [CNT_W-1:0] first_fail_time,
  output logic             pending
);

  if (DELAY < 1) begin : g_bad_delay
    $error("implication_checker: DELAY must be at least 1");
  end
  if (CNT_W < 1 || CNT_W > 32) begin : g_bad_width
    $error("implication_checker: CNT_W must be between 1 and 32");
  end

  localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

  logic             w_flush;
  logic             w_issue;
  logic             w_matured;
  logic             w_anyPending;
  logic             r_failPulse;
  logic             r_failSticky;
  logic [CNT_W-1:0] r_passCount;
  logic [CNT_W-1:0] r_failCount;
  logic [CNT_W-1:0] r_firstFailTime;
  logic [CNT_W-1:0] r_cycleCount;

  assign w_flush = RESET | clear;
  assign w_issue = antecedent & enable;

  obligation_pipe #(
    .DELAY(DELAY)
  ) u_pipe (
    .i_clk        (CLK),
    .i_flush      (w_flush),
    .i_obligation (w_issue),
    .o_matured    (w_matured),
    .o_anyPending (w_anyPending)
  );

  // Flush has priority over maturation, so an obligation evaluated on the
  // same edge as RESET/clear is discarded without being counted. The fail
  // pulse is registered, which places it in the cycle after the evaluation.
  always_ff @(posedge CLK) begin
    if (w_flush) begin
      r_failPulse     <= 1'b0;
      r_failSticky    <= 1'b0;
      r_passCount     <= '0;
      r_failCount     <= '0;
      r_firstFailTime <= '0;
      r_cycleCount    <= '0;
    end else begin
      r_cycleCount <= r_cycleCount + CNT_W'(1);
      r_failPulse  <= 1'b0;
      if (w_matured) begin
        if (consequent) begin
          r_passCount <= CNT_W'(sat_inc(32'(r_passCount), CNT_MAX));
        end else begin
          r_failCount <= CNT_W'(sat_inc(32'(r_failCount), CNT_MAX));
          r_failPulse <= 1'b1;
          if (!r_failSticky) begin
            r_failSticky    <= 1'b1;
            r_firstFailTime <= r_cycleCount;
          end
        end
      end
    end
  end

  assign fail_pulse      = r_failPulse;
  assign fail_sticky     = r_failSticky;
  assign pass_count      = r_passCount;
  assign fail_count      = r_failCount;
  assign first_fail_time = r_firstFailTime;
  assign pending         = w_anyPending;

endmodule
